im_loader: RTL and testbench
============================

Name: im_loader

Overview:
Writer side of the instruction-memory interface. It accepts a byte stream over a valid/ready handshake and packs each group of 4 bytes into a 32-bit instruction word. Each packed word is written into the instruction memory at consecutive word-aligned byte addresses starting at 0. The block holds the pipeline CPU via cpu_hold until the programmed number of words has been written.

Parameters:
ADDR_W, 10, log2 of memory depth in words (1024 words; address bits [ADDR_W+1:2] index the memory)
BYTE_ORDER, 0, 0 = little-endian (first byte -> bits [7:0]); 1 = big-endian (first byte -> bits [31:24])

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
start  in  1  single-cycle pulse; begins a load session
word_count  in  ADDR_W+1  number of words to load; sampled only on an accepted start
byte_data  in  8  incoming stream byte
byte_valid  in  1  byte_data is valid
byte_ready  out  1  loader can accept a byte this cycle
im_we  out  1  instruction-memory write enable, single-cycle pulse
im_addr  out  32  byte address of the write; bits [1:0] always 0
im_wdata  out  32  packed instruction word
busy  out  1  session in progress (LOAD or WRITE)
done  out  1  session complete; level signal
cpu_hold  out  1  keeps the CPU stalled/in reset while high
overflow_err  out  1  word_count exceeded depth; sticky until next accepted start

Behaviour:
- Reset (reset==0 at a clk edge) -> state IDLE. Output values: im_we=0, im_addr=0, im_wdata=0, byte_ready=0, busy=0, done=0, overflow_err=0, cpu_hold=1. Reset mid-session abandons it immediately; a partially packed word is never written.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - byte_ready=0, cpu_hold=1.
  - start=1 -> latch remaining=min(word_count, 2**ADDR_W) and set addr=0, byte_idx=0.
  - overflow_err <= (word_count > 2**ADDR_W).
  - If the latched count is nonzero, go to LOAD; if it is zero, go to DONE.
- LOAD:
  - byte_ready=1, busy=1.
  - A byte transfers only when byte_valid && byte_ready at the clk edge. The byte is placed per BYTE_ORDER at lane byte_idx, then byte_idx increments (2-bit, wraps).
  - The 4th accepted byte -> WRITE next cycle.
  - byte_valid while byte_ready=0 is not consumed; the source must hold the byte.
- WRITE:
  - Lasts exactly one cycle with byte_ready=0, im_we=1, im_addr=addr, im_wdata=packed word. These are registered outputs, stable for the whole cycle.
  - Next edge: addr+=4, remaining-=1. If remaining becomes 0 -> DONE, else -> LOAD.
- DONE:
  - done=1, cpu_hold=0, busy=0, byte_ready=0, im_we=0.
  - start=1 -> restart exactly as from IDLE: done clears next cycle and cpu_hold returns to 1.
- start is ignored in LOAD and WRITE.
- Throughput: minimum 5 cycles per word (4 byte transfers + 1 write cycle).
- Address wrap: impossible, because the count is clamped to depth. The last write goes to (2**ADDR_W - 1)*4.
- im_addr is a full 32-bit byte address, compatible with memory indexed by PC[ADDR_W+1:2]. Upper bits above ADDR_W+1 are always 0.
- im_wdata holds its last value outside WRITE. im_we is 0 in every state other than WRITE.

Decomposition:
- Shared package: state encoding enum (IDLE/LOAD/WRITE/DONE), BYTE_ORDER constants (LITTLE=0, BIG=1), and the IM depth constant (ADDR_W default) shared with the instruction memory.
- One natural sub-module, im_byte_packer: takes byte, lane index, accept strobe and BYTE_ORDER, and produces the 32-bit word register. The FSM, counters and handshake stay in im_loader.

Test Plan:
- Reset: hold reset=0 for 3 cycles with byte_valid=1 -> byte_ready=0, im_we=0, done=0, cpu_hold=1, im_addr=0.
- Little-endian single word: start with word_count=1, then bytes 0x78,0x56,0x34,0x12 with byte_valid held high -> exactly one im_we pulse, im_addr=0x0, im_wdata=0x12345678. One cycle later done=1 and cpu_hold=0.
- Multi-word with gaps: BYTE_ORDER=1, word_count=3, random byte_valid deassertion, bytes 00..0B -> writes 0x00010203 @0x0, 0x04050607 @0x4, 0x08090A0B @0x8. No byte is lost or duplicated, and no writes occur after done.
- Zero count and overflow:
  - word_count=0 -> DONE the cycle after start, with no im_we.
  - word_count=1025 (ADDR_W=10) -> overflow_err=1 and exactly 1024 writes, the last at 0xFFC.
- Start while busy: pulse start mid-word during a 2-word load -> ignored; addresses and data are unchanged versus the reference model.
- Reset mid-session: assert reset after 2 bytes of word 1 -> no im_we. Then restart with word_count=1 and bytes 0xAA,0xBB,0xCC,0xDD -> im_wdata=0xDDCCBBAA @0x0.

Source files
------------

// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding,
// byte-order selectors, default memory depth and the byte-lane placement helper.
package im_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } im_state_e;

  localparam int unsigned ORDER_LITTLE = 0;
  localparam int unsigned ORDER_BIG    = 1;

  // Word-address width of the instruction memory (1024 words).
  localparam int unsigned IM_ADDR_W = 10;

  function automatic logic [31:0] place_byte(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  data,
                                             input int unsigned order);
    logic [1:0]  eff;
    logic [31:0] res;
    eff = (order == ORDER_BIG) ? (2'd3 - lane) : lane;
    res = word;
    res[{eff, 3'b000} +: 8] = data;
    return res;
  endfunction

endpackage

// File: rtl/im_byte_packer.sv
// Assembles four stream bytes into one 32-bit word; o_word_next already
// includes the byte accepted this cycle so the loader can capture a full word.
module im_byte_packer
  import im_loader_pkg::*;
#(
  parameter int unsigned BYTE_ORDER = ORDER_LITTLE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clr,
  input  logic        i_accept,
  input  logic [1:0]  i_lane,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word_next
);

  logic [31:0] r_word;

  // Merge the accepted byte into its lane.
  always_comb begin
    o_word_next = r_word;
    if (i_accept) begin
      o_word_next = place_byte(r_word, i_lane, i_byte, BYTE_ORDER);
    end else begin
      o_word_next = r_word;
    end
  end

  // Word register; cleared at session start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_word <= 32'd0;
    end else if (i_clr) begin
      r_word <= 32'd0;
    end else if (i_accept) begin
      r_word <= o_word_next;
    end
  end

endmodule

// File: rtl/im_loader.sv
// Instruction-memory loader: packs a byte stream into words, writes them at
// consecutive word addresses from 0 and holds the CPU until the load completes.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int unsigned ADDR_W     = IM_ADDR_W,
  parameter int unsigned BYTE_ORDER = ORDER_LITTLE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [ADDR_W:0] word_count,
  input  logic [7:0]      byte_data,
  input  logic            byte_valid,
  output logic            byte_ready,
  output logic            im_we,
  output logic [31:0]     im_addr,
  output logic [31:0]     im_wdata,
  output logic            busy,
  output logic            done,
  output logic            cpu_hold,
  output logic            overflow_err
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  im_state_e         r_state, w_next_state;
  logic [ADDR_W:0]   r_remaining;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_byte_idx;
  logic              r_byte_ready, r_im_we, r_busy, r_done, r_cpu_hold, r_overflow;
  logic [31:0]       r_im_addr, r_im_wdata;
  logic              w_start_ok, w_accept;
  logic [ADDR_W:0]   w_count_clamped;
  logic [31:0]       w_word_next;

  assign w_accept        = byte_valid && r_byte_ready && (r_state == ST_LOAD);
  assign w_count_clamped = (word_count > DEPTH) ? DEPTH : word_count;

  // Next-state decode; start is only honoured in IDLE and DONE.
  always_comb begin
    w_next_state = r_state;
    w_start_ok   = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_start_ok   = 1'b1;
          w_next_state = (w_count_clamped != {(ADDR_W+1){1'b0}}) ? ST_LOAD : ST_DONE;
        end else begin
          w_next_state = r_state;
        end
      end
      ST_LOAD: begin
        if (w_accept && (r_byte_idx == 2'd3)) begin
          w_next_state = ST_WRITE;
        end else begin
          w_next_state = ST_LOAD;
        end
      end
      ST_WRITE: begin
        if (r_remaining == ONE) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_LOAD;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Session counters and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_remaining <= {(ADDR_W+1){1'b0}};
      r_addr      <= {ADDR_W{1'b0}};
      r_byte_idx  <= 2'd0;
      r_overflow  <= 1'b0;
    end else if (w_start_ok) begin
      r_remaining <= w_count_clamped;
      r_addr      <= {ADDR_W{1'b0}};
      r_byte_idx  <= 2'd0;
      r_overflow  <= (word_count > DEPTH);
    end else begin
      if (w_accept) begin
        r_byte_idx <= r_byte_idx + 2'd1;
      end
      if (r_state == ST_WRITE) begin
        r_addr      <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
        r_remaining <= r_remaining - ONE;
      end
    end
  end

  // Outputs are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_byte_ready <= 1'b0;
      r_im_we      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cpu_hold   <= 1'b1;
      r_im_addr    <= 32'd0;
      r_im_wdata   <= 32'd0;
    end else begin
      r_byte_ready <= (w_next_state == ST_LOAD);
      r_im_we      <= (w_next_state == ST_WRITE);
      r_busy       <= (w_next_state == ST_LOAD) || (w_next_state == ST_WRITE);
      r_done       <= (w_next_state == ST_DONE);
      r_cpu_hold   <= (w_next_state != ST_DONE);
      if (w_next_state == ST_WRITE) begin
        r_im_addr  <= {{(32-ADDR_W-2){1'b0}}, r_addr, 2'b00};
        r_im_wdata <= w_word_next;
      end
    end
  end

  im_byte_packer #(
    .BYTE_ORDER(BYTE_ORDER)
  ) u_packer (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_start_ok),
    .i_accept   (w_accept),
    .i_lane     (r_byte_idx),
    .i_byte     (byte_data),
    .o_word_next(w_word_next)
  );

  assign byte_ready   = r_byte_ready;
  assign im_we        = r_im_we;
  assign im_addr      = r_im_addr;
  assign im_wdata     = r_im_wdata;
  assign busy         = r_busy;
  assign done         = r_done;
  assign cpu_hold     = r_cpu_hold;
  assign overflow_err = r_overflow;

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench: little- and big-endian loaders share one byte stream;
// expected writes are queued by the driver and popped by per-instance monitors.
module tb_im_loader;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [AW:0] word_count = '0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_valid = 1'b0;

  logic        le_byte_ready, le_im_we, le_busy, le_done, le_cpu_hold, le_overflow;
  logic [31:0] le_im_addr, le_im_wdata;
  logic        be_byte_ready, be_im_we, be_busy, be_done, be_cpu_hold, be_overflow;
  logic [31:0] be_im_addr, be_im_wdata;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_le    = 0;
  int wr_be    = 0;

  logic [63:0] exp_le_q[$];
  logic [63:0] exp_be_q[$];
  logic [7:0]  src_q[$];

  always #5 clk = ~clk;

  im_loader #(.ADDR_W(AW), .BYTE_ORDER(0)) u_le (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(le_byte_ready),
    .im_we(le_im_we), .im_addr(le_im_addr), .im_wdata(le_im_wdata),
    .busy(le_busy), .done(le_done), .cpu_hold(le_cpu_hold), .overflow_err(le_overflow)
  );

  im_loader #(.ADDR_W(AW), .BYTE_ORDER(1)) u_be (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(be_byte_ready),
    .im_we(be_im_we), .im_addr(be_im_addr), .im_wdata(be_im_wdata),
    .busy(be_busy), .done(be_done), .cpu_hold(be_cpu_hold), .overflow_err(be_overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Little-endian write monitor.
  always @(negedge clk) begin
    if (le_im_we === 1'b1) begin
      logic [63:0] e;
      wr_le++;
      if (exp_le_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL le_unexpected_write: got addr %08h data %08h expected no write", le_im_addr, le_im_wdata);
      end else begin
        e = exp_le_q.pop_front();
        chk("le_addr", le_im_addr, e[63:32]);
        chk("le_data", le_im_wdata, e[31:0]);
      end
    end
  end

  // Big-endian write monitor.
  always @(negedge clk) begin
    if (be_im_we === 1'b1) begin
      logic [63:0] e;
      wr_be++;
      if (exp_be_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL be_unexpected_write: got addr %08h data %08h expected no write", be_im_addr, be_im_wdata);
      end else begin
        e = exp_be_q.pop_front();
        chk("be_addr", be_im_addr, e[63:32]);
        chk("be_data", be_im_wdata, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed_byte(input logic [7:0] b, input int gap_pct);
    int guard;
    bit acc;
    guard = 0;
    acc = 1'b0;
    byte_data = b;
    while (!acc && guard < 100) begin
      byte_valid = ($urandom_range(99) >= gap_pct);
      @(negedge clk);
      acc = byte_valid && le_byte_ready;
      tick();
      guard++;
    end
    byte_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_timeout: got no acceptance of %02h expected acceptance within 100 cycles", b);
    end
  endtask

  task automatic do_start(input int count);
    start = 1'b1;
    word_count = count[AW:0];
    tick();
    start = 1'b0;
  endtask

  task automatic run_session(input int count, input int gap_pct, input bit mid_start);
    int nw;
    bit ov;
    int base_le, base_be;
    logic [7:0] b[4];
    nw = (count > DEPTH) ? DEPTH : count;
    ov = (count > DEPTH);
    base_le = wr_le;
    base_be = wr_be;
    do_start(count);
    @(negedge clk);
    chk("overflow_at_start", {31'd0, le_overflow}, {31'd0, ov});
    if (nw == 0) begin
      chk("zero_done", {31'd0, le_done}, 32'd1);
      chk("zero_cpu_hold", {31'd0, le_cpu_hold}, 32'd0);
    end else begin
      chk("start_busy", {31'd0, le_busy}, 32'd1);
      chk("start_ready", {31'd0, le_byte_ready}, 32'd1);
      chk("start_cpu_hold", {31'd0, be_cpu_hold}, 32'd1);
    end
    tick();
    for (int w = 0; w < nw; w++) begin
      for (int i = 0; i < 4; i++) begin
        b[i] = (src_q.size() > 0) ? src_q.pop_front() : 8'($urandom);
        feed_byte(b[i], gap_pct);
        if (mid_start && w == 0 && i == 1) do_start(5);
      end
      exp_le_q.push_back({32'(w * 4), b[3], b[2], b[1], b[0]});
      exp_be_q.push_back({32'(w * 4), b[0], b[1], b[2], b[3]});
      @(negedge clk);
      chk("write_pulse", {31'd0, le_im_we}, 32'd1);
      chk("write_no_ready", {31'd0, le_byte_ready}, 32'd0);
      tick();
      @(negedge clk);
      if (w == nw - 1) begin
        chk("done_after_write", {31'd0, le_done}, 32'd1);
        chk("cpu_release", {31'd0, le_cpu_hold}, 32'd0);
        chk("busy_clear", {31'd0, be_busy}, 32'd0);
      end else begin
        chk("reload_ready", {31'd0, le_byte_ready}, 32'd1);
      end
      tick();
    end
    repeat (3) tick();
    chk("le_write_count", 32'(wr_le - base_le), 32'(nw));
    chk("be_write_count", 32'(wr_be - base_be), 32'(nw));
    chk("overflow_sticky", {31'd0, be_overflow}, {31'd0, ov});
    chk("done_level", {31'd0, le_done}, 32'd1);
  endtask

  task automatic check_reset_outputs();
    @(negedge clk);
    chk("rst_ready", {31'd0, le_byte_ready}, 32'd0);
    chk("rst_we", {31'd0, le_im_we}, 32'd0);
    chk("rst_done", {31'd0, le_done}, 32'd0);
    chk("rst_cpu_hold", {31'd0, le_cpu_hold}, 32'd1);
    chk("rst_addr", le_im_addr, 32'd0);
    chk("rst_busy", {31'd0, be_busy}, 32'd0);
    chk("rst_overflow", {31'd0, be_overflow}, 32'd0);
    chk("rst_wdata", be_im_wdata, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    byte_valid = 1'b1;
    repeat (3) tick();
    check_reset_outputs();
    byte_valid = 1'b0;
    reset = 1'b1;
    tick();

    // Little-endian single word.
    src_q = '{8'h78, 8'h56, 8'h34, 8'h12};
    run_session(1, 0, 1'b0);

    // Three words, sequential bytes, with valid gaps.
    for (int i = 0; i < 12; i++) src_q.push_back(8'(i));
    run_session(3, 40, 1'b0);

    // Zero count.
    run_session(0, 0, 1'b0);

    // Start pulsed mid-word is ignored.
    run_session(2, 20, 1'b1);

    // Random sessions.
    for (int k = 0; k < 3; k++) run_session(int'($urandom_range(6, 1)), 30, 1'b0);

    // Reset mid-session after two bytes of the first word.
    do_start(2);
    tick();
    feed_byte(8'h11, 0);
    feed_byte(8'h22, 0);
    reset = 1'b0;
    byte_valid = 1'b1;
    repeat (3) tick();
    check_reset_outputs();
    byte_valid = 1'b0;
    reset = 1'b1;
    tick();
    src_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_session(1, 0, 1'b0);

    // Over-depth count is clamped to full depth.
    run_session(DEPTH + 1, 0, 1'b0);

    chk("le_queue_drained", 32'(exp_le_q.size()), 32'd0);
    chk("be_queue_drained", 32'(exp_be_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
